// File: rtl/neuron_out_arbiter.sv
// Round-robin arbiter that pulls one 8-bit serial word at a time from four
// neuron OUT channels, buffers it, and replays it downstream tagged with its source port.
module neuron_out_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [3:0] MASK,
  output logic [3:0] N_REQ,
  input  logic [3:0] N_ACK,
  input  logic [3:0] N_DATA,
  input  logic       DN_REQ,
  output logic       DN_ACK,
  output logic       DN_DATA,
  output logic [1:0] DN_ID,
  output logic       BUSY,
  output logic [7:0] SKIP_CNT
);

  typedef enum logic [2:0] {IDLE, GRANT, RECV, HOLD, SEND} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n, sel, sel_n, pick;
  logic       found;
  logic [7:0] wait_cnt, wait_n, wbuf, wbuf_n, skip_n;
  logic [2:0] bit_cnt, bit_n;
  logic [3:0] n_req_n;
  logic       dn_ack_n, dn_data_n;
  logic [1:0] dn_id_n;

  // First enabled port after the last serviced one; i==4 wraps back onto ptr.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && MASK[ptr + 2'(i)]) begin
        pick  = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    wait_n    = wait_cnt;
    wbuf_n    = wbuf;
    bit_n     = bit_cnt;
    skip_n    = SKIP_CNT;
    n_req_n   = N_REQ;
    dn_ack_n  = 1'b0;
    dn_data_n = DN_DATA;
    dn_id_n   = DN_ID;
    case (state)
      IDLE: begin
        if (found) begin
          sel_n   = pick;
          n_req_n = 4'(1) << pick;
          wait_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // An ACK on the timeout edge still wins.
        if (N_ACK[sel]) begin
          wbuf_n[0] = N_DATA[sel];
          n_req_n   = '0;
          bit_n     = 3'd1;
          state_n   = RECV;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          n_req_n = '0;
          ptr_n   = sel;
          skip_n  = (SKIP_CNT == 8'hFF) ? SKIP_CNT : SKIP_CNT + 8'd1;
          state_n = IDLE;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      RECV: begin
        wbuf_n[bit_cnt] = N_DATA[sel];
        bit_n           = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = HOLD;
      end
      HOLD: begin
        if (DN_REQ) begin
          dn_ack_n  = 1'b1;
          dn_data_n = wbuf[0];
          dn_id_n   = sel;
          bit_n     = 3'd1;
          state_n   = SEND;
        end
      end
      SEND: begin
        // bit_cnt wraps to 0 once bit 7 has been on the line for a cycle.
        if (bit_cnt == 3'd0) begin
          dn_data_n = 1'b0;
          ptr_n     = sel;
          state_n   = IDLE;
        end else begin
          dn_data_n = wbuf[bit_cnt];
          bit_n     = bit_cnt + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      sel      <= '0;
      wait_cnt <= '0;
      wbuf     <= '0;
      bit_cnt  <= '0;
      SKIP_CNT <= '0;
      N_REQ    <= '0;
      DN_ACK   <= 1'b0;
      DN_DATA  <= 1'b0;
      DN_ID    <= '0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      wait_cnt <= wait_n;
      wbuf     <= wbuf_n;
      bit_cnt  <= bit_n;
      SKIP_CNT <= skip_n;
      N_REQ    <= n_req_n;
      DN_ACK   <= dn_ack_n;
      DN_DATA  <= dn_data_n;
      DN_ID    <= dn_id_n;
      BUSY     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_neuron_out_arbiter.sv
// Scoreboard bench: behavioural neuron models feed the arbiter, a round-robin
// reference predicts the downstream words, and a monitor checks each one as it arrives.
module tb_neuron_out_arbiter;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic [3:0] MASK = '0;
  logic [3:0] N_REQ;
  logic [3:0] N_ACK = '0;
  logic [3:0] N_DATA = '0;
  logic       DN_REQ = 1'b0;
  logic       DN_ACK, DN_DATA, BUSY;
  logic [1:0] DN_ID;
  logic [7:0] SKIP_CNT;

  always #5 CLK = ~CLK;

  neuron_out_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RSTB(RSTB), .MASK(MASK), .N_REQ(N_REQ), .N_ACK(N_ACK),
    .N_DATA(N_DATA), .DN_REQ(DN_REQ), .DN_ACK(DN_ACK), .DN_DATA(DN_DATA),
    .DN_ID(DN_ID), .BUSY(BUSY), .SKIP_CNT(SKIP_CNT)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
  } word_t;

  int         tests = 0;
  int         fails = 0;
  word_t      exp_q[$];
  int         words_seen = 0;
  logic [3:0] forbid = '0;
  bit         dn_rand = 1'b0;

  logic [7:0] data_tab [4][16];
  logic [7:0] fixed_val [4] = '{8'h05, 8'h7F, 8'h00, 8'h3C};
  int         nidx [4];
  int         lat [4];
  int         waitc [4];
  int         phase [4];
  logic [7:0] cur [4];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Neuron producers: ACK after lat[k] cycles of REQ, then 7 more data bits.
  initial forever begin
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      if (!RSTB) begin
        phase[k] = 0; waitc[k] = 0; N_ACK[k] = 1'b0; N_DATA[k] = 1'b0;
      end else if (phase[k] != 0) begin
        N_ACK[k]  = 1'b0;
        N_DATA[k] = cur[k][phase[k]];
        phase[k]  = (phase[k] == 7) ? 0 : phase[k] + 1;
      end else if (N_REQ[k]) begin
        if (waitc[k] == lat[k]) begin
          cur[k]    = (nidx[k] < 16) ? data_tab[k][nidx[k]] : 8'h00;
          nidx[k]++;
          N_ACK[k]  = 1'b1;
          N_DATA[k] = cur[k][0];
          phase[k]  = 1;
          waitc[k]  = 0;
        end else begin
          waitc[k]++;
          N_ACK[k] = 1'b0; N_DATA[k] = 1'b0;
        end
      end else begin
        N_ACK[k] = 1'b0; N_DATA[k] = 1'b0; waitc[k] = 0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (dn_rand) DN_REQ = ($urandom_range(3) != 0);
  end

  // Downstream monitor
  int         mb = 0;
  bit         coll = 1'b0;
  logic [7:0] mw;
  logic [1:0] mid;
  word_t      me;
  initial forever begin
    @(negedge CLK);
    if (!RSTB) begin
      coll = 1'b0;
    end else begin
      check("nreq_onehot", 32'($onehot0(N_REQ)), 32'd1);
      if (forbid != 4'b0000) check("nreq_masked_port", N_REQ & forbid, 4'b0000);
      if (coll) begin
        mw[mb] = DN_DATA;
        check("dn_ack_single", DN_ACK, 1'b0);
        check("dn_id_stable", DN_ID, mid);
        mb++;
        if (mb == 8) begin
          coll = 1'b0;
          words_seen++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL dn_word: got unexpected %0h/id%0d, expected none", mw, mid);
          end else begin
            me = exp_q.pop_front();
            check("dn_word", {mw, mid}, {me.data, me.id});
          end
        end
      end else if (DN_ACK) begin
        coll = 1'b1; mb = 1; mw = '0; mw[0] = DN_DATA; mid = DN_ID;
      end
    end
  end

  function automatic int next_port(int p, logic [3:0] m);
    for (int i = 1; i <= 4; i++) if (m[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTB = 1'b0; MASK = '0; forbid = '0; dn_rand = 1'b0; DN_REQ = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin nidx[k] = 0; lat[k] = 0; end
    repeat (2) @(negedge CLK);
    words_seen = 0;
    RSTB = 1'b1;
  endtask

  task automatic wait_words(string tag, int n, int budget);
    int b = budget;
    while (words_seen < n && b > 0) begin @(negedge CLK); b--; end
    check({tag, "_words"}, words_seen, n);
  endtask

  task automatic run_phase(string tag, logic [3:0] mask, int nwords, int stall,
                           bit fixed, int lat_fix, bit rnd_dn);
    int    p = 3, pushed = 0, skips = 0;
    int    used [4];
    word_t e;
    do_reset();
    forbid = ~mask;
    for (int k = 0; k < 4; k++) begin
      used[k] = 0;
      for (int i = 0; i < 16; i++) data_tab[k][i] = fixed ? fixed_val[k] : 8'($urandom);
      lat[k] = (k == stall) ? 1000 : ((lat_fix >= 0) ? lat_fix : $urandom_range(12));
    end
    while (pushed < nwords) begin
      p = next_port(p, mask);
      if (p == stall) skips++;
      else begin
        e.data = data_tab[p][used[p]]; e.id = 2'(p);
        used[p]++; pushed++;
        exp_q.push_back(e);
      end
    end
    dn_rand = rnd_dn;
    if (!rnd_dn) DN_REQ = 1'b1;
    MASK = mask;
    wait_words(tag, nwords, nwords * 80 + skips * 20 + 50);
    check({tag, "_leftover"}, exp_q.size(), 0);
    check({tag, "_skip_cnt"}, SKIP_CNT, skips);
    MASK = '0;
  endtask

  task automatic hold_test();
    int    b;
    word_t e;
    do_reset();
    data_tab[0][0] = 8'hA5; lat[0] = 2;
    e.data = 8'hA5; e.id = 2'd0; exp_q.push_back(e);
    MASK = 4'b0001;
    b = 50;
    while (!N_ACK[0] && b > 0) begin @(negedge CLK); b--; end
    repeat (12) @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("hold_busy", BUSY, 1'b1);
      check("hold_no_nreq", N_REQ, 4'b0000);
      check("hold_no_dn_ack", DN_ACK, 1'b0);
    end
    DN_REQ = 1'b1;
    @(negedge CLK);
    check("hold_dn_ack_next", {DN_ACK, DN_DATA}, 2'b11);
    wait_words("hold", 1, 40);
  endtask

  task automatic reset_test();
    int b;
    do_reset();
    for (int i = 0; i < 16; i++) data_tab[0][i] = 8'($urandom);
    DN_REQ = 1'b1; MASK = 4'b0001;
    b = 50;
    while (!N_ACK[0] && b > 0) begin @(negedge CLK); b--; end
    repeat (5) @(posedge CLK);
    #2;
    check("rst_pre_busy", BUSY, 1'b1);
    RSTB = 1'b0;
    #1;
    check("rst_async_outputs", {N_REQ, DN_ACK, DN_DATA, DN_ID, BUSY, SKIP_CNT}, 0);
    repeat (2) @(negedge CLK);
    MASK = 4'b1111;
    RSTB = 1'b1;
    b = 20;
    while (N_REQ == 4'b0000 && b > 0) begin @(negedge CLK); b--; end
    check("rst_first_grant", N_REQ, 4'b0001);
  endtask

  task automatic timeout_test();
    int b, dur;
    do_reset();
    lat[2] = 1000; forbid = 4'b1011; DN_REQ = 1'b1; MASK = 4'b0100;
    for (int a = 1; a <= 3; a++) begin
      b = 50;
      while (!N_REQ[2] && b > 0) begin @(negedge CLK); b--; end
      dur = 0;
      while (N_REQ[2] && dur < 100) begin @(negedge CLK); dur++; end
      check("timeout_req_width", dur, 16);
      check("timeout_skip_inc", SKIP_CNT, a);
    end
    b = 300 * 18;
    while (SKIP_CNT != 8'hFF && b > 0) begin @(negedge CLK); b--; end
    check("timeout_saturate", SKIP_CNT, 8'hFF);
    repeat (100) @(negedge CLK);
    check("timeout_hold_255", SKIP_CNT, 8'hFF);
    check("timeout_no_word", words_seen, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] m;
    int         st;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {N_REQ, DN_ACK, DN_DATA, DN_ID, BUSY, SKIP_CNT}, 0);
    RSTB = 1'b1;
    run_phase("rr_fixed", 4'b1111, 5, -1, 1'b1, -1, 1'b0);
    run_phase("mask_1010", 4'b1010, 6, -1, 1'b0, -1, 1'b1);
    run_phase("ack_at_timeout", 4'b0001, 2, -1, 1'b0, 15, 1'b0);
    run_phase("stall_skip", 4'b1110, 5, 2, 1'b0, -1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      m  = 4'($urandom_range(15, 1));
      st = -1;
      if ($countones(m) >= 2 && $urandom_range(1) == 1) begin
        do st = $urandom_range(3); while (!m[st]);
      end
      run_phase("random", m, $urandom_range(8, 4), st, 1'b0, -1, 1'b1);
    end
    hold_test();
    reset_test();
    timeout_test();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
